// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scan controller: digit width, digit index
// and the scan FSM state encoding.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] digit_t;
    typedef logic [2:0] digit_idx_t;

    typedef enum logic [1:0] {
        OFF,
        GUARD,
        DRIVE
    } scan_state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter for the scan controller: counts through one digit slot and
// strobes when the blanking guard ends and when the whole slot ends.
module scan_tick_gen #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic guard_done,
    output logic slot_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign guard_done = run && (cnt == GUARD_LAST);
    assign slot_done  = run && (cnt == SLOT_LAST);

    // Held at zero while idle so a restart always begins with a full guard.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (slot_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller: digit registers, a
// blank-guarded scan FSM and active-low anode drive for an external decoder.
module seven_seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] blank_mask,
    output logic [2:0] sel,
    output logic [3:0] num,
    output logic [7:0] an_n,
    output logic       frame_tick
);

    scan_state_t state;
    scan_state_t next_state;
    digit_t      digit_reg [NUM_DIGITS];
    digit_idx_t  sel_next;
    logic        guard_done;
    logic        slot_done;
    logic        run;

    assign run = en && (state != OFF);

    scan_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV),
        .GUARD_CYC  (GUARD_CYC)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .guard_done(guard_done),
        .slot_done (slot_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            OFF:     if (en) next_state = GUARD;
            GUARD:   if (guard_done) next_state = DRIVE;
            DRIVE:   if (slot_done) next_state = GUARD;
            default: next_state = OFF;
        endcase
        if (!en) begin
            next_state = OFF;
        end
    end

    assign sel_next = sel + 3'd1;

    // frame_tick is registered alongside sel so it lines up with the first sel=0 cycle.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            sel        <= '0;
            frame_tick <= 1'b0;
        end else if (state == DRIVE && slot_done) begin
            sel        <= sel_next;
            frame_tick <= (sel == 3'd7);
        end else begin
            frame_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
        end else if (wr_en) begin
            digit_reg[wr_addr] <= wr_data;
        end
    end

    assign num = digit_reg[sel];

    always_comb begin
        an_n = 8'hFF;
        if (state == DRIVE && !blank_mask[sel]) begin
            an_n = ~(8'b1 << sel);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with a short slot (8 cycles,
// 2 guard); a time-since-enable model feeds a per-cycle scoreboard.
module tb_seven_seg_scan_ctrl;

    localparam int RD = 8;
    localparam int GC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [7:0] blank_mask = '0;
    logic [2:0] sel;
    logic [3:0] num;
    logic [7:0] an_n;
    logic       frame_tick;

    typedef struct {
        logic [7:0] an_n;
        logic [2:0] sel;
        logic [3:0] num;
        logic       tick;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         m_t = -1;
    logic [3:0] m_dig [8];
    int         ticks_seen;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV(RD),
        .GUARD_CYC  (GC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .blank_mask(blank_mask),
        .sel       (sel),
        .num       (num),
        .an_n      (an_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic int m_sel();
        return (m_t < 0) ? 0 : (m_t / RD) % 8;
    endfunction

    function automatic int m_phase();
        return (m_t < 0) ? 0 : m_t % RD;
    endfunction

    task automatic check_output();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=%0d expected=>0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (an_n === e.an_n) else begin
                errors++;
                $error("[TB] FAIL an_n t=%0d observed=%h expected=%h", m_t, an_n, e.an_n);
            end
            checks++;
            assert (sel === e.sel) else begin
                errors++;
                $error("[TB] FAIL sel t=%0d observed=%0d expected=%0d", m_t, sel, e.sel);
            end
            checks++;
            assert (num === e.num) else begin
                errors++;
                $error("[TB] FAIL num t=%0d observed=%h expected=%h", m_t, num, e.num);
            end
            checks++;
            assert (frame_tick === e.tick) else begin
                errors++;
                $error("[TB] FAIL frame_tick t=%0d observed=%b expected=%b", m_t, frame_tick, e.tick);
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, queue the
    // expected outputs, then compare just after the edge.
    task automatic apply_stimulus();
        exp_t e;
        int   s;
        @(posedge clk);
        if (rst) begin
            m_t = -1;
            for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
        end else begin
            if (wr_en) m_dig[wr_addr] = wr_data;
            m_t = en ? m_t + 1 : -1;
        end
        s = m_sel();
        e.sel  = 3'(s);
        e.num  = m_dig[s];
        e.tick = (m_t > 0) && (m_t % (RD * 8) == 0);
        if (m_t < 0 || m_phase() < GC || blank_mask[s]) e.an_n = 8'hFF;
        else e.an_n = ~(8'b1 << s);
        sb.push_back(e);
        #1;
        check_output();
        if (frame_tick === 1'b1) ticks_seen++;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) apply_stimulus();
    endtask

    task automatic wait_slot(input int s, input int ph, input string tag);
        int k;
        k = 0;
        while (!(m_t >= 0 && m_sel() == s && m_phase() == ph) && k < 200) begin
            apply_stimulus();
            k++;
        end
        checks++;
        assert (k < 200) else begin
            errors++;
            $error("[TB] FAIL %s_timeout observed=%0d expected=<200", tag, k);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;

        // Reset, then enable: guard/drive pattern for slots 0 and 1.
        run_cycles(2);
        rst = 1'b0;
        en  = 1'b1;
        run_cycles(20);

        // Load digits 0..7 with 1..8 and scan two full frames.
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 1);
            apply_stimulus();
        end
        wr_en = 1'b0;
        ticks_seen = 0;
        run_cycles(128);
        checks++;
        assert (ticks_seen == 2) else begin
            errors++;
            $error("[TB] FAIL frame_tick_count observed=%0d expected=2", ticks_seen);
        end

        // Blank digit 2 for a full frame, then change the mask mid-drive.
        blank_mask = 8'h04;
        run_cycles(64);
        wait_slot(4, 4, "mask_mid");
        blank_mask = 8'h10;
        run_cycles(2);
        blank_mask = 8'h00;
        run_cycles(2);

        // Write digit 3 while it is being driven.
        wait_slot(3, 3, "wr_sel3");
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 4'hA;
        apply_stimulus();
        wr_en = 1'b0;
        run_cycles(3);

        // Drop enable during digit 5, then re-enable.
        wait_slot(5, 4, "en_drop");
        en = 1'b0;
        run_cycles(3);
        en = 1'b1;
        run_cycles(12);

        // Reset mid-slot together with a write to digit 1.
        wait_slot(2, 4, "rst_mid");
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 4'hF;
        apply_stimulus();
        rst   = 1'b0;
        wr_en = 1'b0;
        run_cycles(2);
        wait_slot(1, 3, "after_rst");
        checks++;
        assert (num === 4'h0) else begin
            errors++;
            $error("[TB] FAIL digit1_after_rst observed=%h expected=0", num);
        end
        run_cycles(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
